// File: rtl/parallel_to_serial.sv
// Parallel-to-serial converter for RS codeword/information frames.
// A small frame FIFO feeds a shift register that emits one bit per
// accepted handshake, LSB first, with zero-bubble back-to-back frames.
module parallel_to_serial #(
    parameter int N            = 200,
    parameter int K            = 168,
    parameter int SYMBOL_WIDTH = 8,
    parameter     MODE         = "ENCODE",
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N*SYMBOL_WIDTH-1:0] parallel_data_in,
    input  logic                      parallel_data_valid,
    output logic                      parallel_data_ready,
    output logic                      serial_data_out,
    output logic                      serial_data_valid,
    input  logic                      serial_data_ready,
    output logic                      busy,
    output logic [15:0]               bits_remaining,
    output logic [3:0]                frames_buffered,
    output logic                      buffer_empty,
    output logic [31:0]               frames_sent
);

    localparam int FRAME_BITS = (MODE == "DECODE") ? K*SYMBOL_WIDTH : N*SYMBOL_WIDTH;
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      FRAME_LEN = 16'(FRAME_BITS);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [FRAME_BITS-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_count;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [15:0]             bit_cnt;
    logic [31:0]             sent_cnt;
    logic                    out_of_reset;
    logic [FRAME_BITS-1:0]   frame_in;
    logic                    push;
    logic                    pop;
    logic                    xfer;
    logic                    last_bit;
    logic                    unused_input_bits;

    // In DECODE mode the parity symbols above the information field are
    // dropped here; the reduction just keeps the full input bus referenced.
    assign frame_in          = parallel_data_in[FRAME_BITS-1:0];
    assign unused_input_bits = ^parallel_data_in;

    // Ready depends only on flops so the upstream handshake has no
    // combinational loop; out_of_reset holds it low through reset.
    assign parallel_data_ready = out_of_reset && (fifo_count < DEPTH_CNT);
    assign push                = parallel_data_valid && parallel_data_ready;

    assign serial_data_valid = (state == SHIFT);
    assign serial_data_out   = (state == SHIFT) ? shift_reg[0] : 1'b0;
    assign busy              = (state == SHIFT);
    assign bits_remaining    = (state == SHIFT) ? bit_cnt : 16'd0;
    assign frames_buffered   = 4'(fifo_count);
    assign buffer_empty      = (fifo_count == '0);
    assign frames_sent       = sent_cnt;

    // Next-state logic and the pop decision; popping on the last-bit edge
    // keeps consecutive frames gapless.
    always_comb begin
        state_next = state;
        xfer       = 1'b0;
        last_bit   = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                xfer     = serial_data_ready;
                last_bit = serial_data_ready && (bit_cnt == 16'd1);
                if (last_bit) begin
                    if (fifo_count != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame storage; contents need no reset since the count guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= frame_in;
        end
    end

    // FIFO pointers/count, shifter, bit counter and completed-frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_of_reset <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            sent_cnt     <= '0;
        end else begin
            out_of_reset <= 1'b1;
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
                shift_reg <= fifo_mem[rd_ptr];
                bit_cnt   <= FRAME_LEN;
            end else if (xfer) begin
                shift_reg <= shift_reg >> 1;
                bit_cnt   <= bit_cnt - 16'd1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
            if (last_bit) begin
                sent_cnt <= sent_cnt + 32'd1;
            end
        end
    end

endmodule
